// File: rtl/rv32i_pkg.sv
// Shared RV32I types and constants for the writeback stage.
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WRITE    = 2'b10,
        DRAIN    = 2'b11
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module load_extend
    import rv32i_pkg::*;
#(
    parameter int XLEN = rv32i_pkg::XLEN
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // Misaligned halfword offsets fold onto the enclosing aligned halfword.
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   ext = word;
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: selects ALU/PC+4/load result and pulses the register file write port.
// Define WB_FORWARD_EN to drive the forwarding tap; otherwise the tap is tied to zero.
module writeback_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN       = rv32i_pkg::XLEN,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_result_src,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc_plus4,
    input  logic [2:0]            in_funct3,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]       rf_wd3,
    output logic                  rf_we3,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data
);

    wb_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic [1:0]            src_q, src_d;
    logic [XLEN-1:0]       alu_q, alu_d;
    logic [XLEN-1:0]       pc4_q, pc4_d;
    logic [2:0]            f3_q, f3_d;
    logic [XLEN-1:0]       load_q, load_d;
    logic [REG_ADDR_W-1:0] a3_hold_q, a3_hold_d;
    logic [XLEN-1:0]       wd3_hold_q, wd3_hold_d;

    logic                  accept;
    logic                  write_cycle;
    logic [XLEN-1:0]       load_ext;
    logic [XLEN-1:0]       sel_result;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .word   (mem_rdata),
        .offset (alu_q[1:0]),
        .funct3 (f3_q),
        .ext    (load_ext)
    );

    assign in_ready    = (state_q == IDLE) || (state_q == WRITE);
    assign accept      = in_valid & in_ready & ~flush;
    assign write_cycle = (state_q == WRITE);

    always_comb begin
        case (src_q)
            RES_MEM: sel_result = load_q;
            RES_PC4: sel_result = pc4_q;
            default: sel_result = alu_q;
        endcase
    end

    // Write port is driven only from latched state, so a flush arriving in WRITE cannot cancel it.
    assign rf_we3 = write_cycle & reg_write_q & (rd_q != '0);
    assign rf_a3  = write_cycle ? rd_q : a3_hold_q;
    assign rf_wd3 = write_cycle ? sel_result : wd3_hold_q;

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        src_d       = src_q;
        alu_d       = alu_q;
        pc4_d       = pc4_q;
        f3_d        = f3_q;
        load_d      = load_q;
        a3_hold_d   = write_cycle ? rd_q : a3_hold_q;
        wd3_hold_d  = write_cycle ? sel_result : wd3_hold_q;

        case (state_q)
            IDLE, WRITE: begin
                if (accept) begin
                    rd_d        = in_rd;
                    reg_write_d = in_reg_write;
                    src_d       = in_result_src;
                    alu_d       = in_alu_result;
                    pc4_d       = in_pc_plus4;
                    f3_d        = in_funct3;
                    state_d     = (in_result_src == RES_MEM) ? WAIT_MEM : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid && flush) begin
                    state_d = IDLE;
                end else if (mem_rvalid) begin
                    load_d  = load_ext;
                    state_d = WRITE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Swallow the response of the cancelled load so only one is ever in flight.
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            src_q       <= '0;
            alu_q       <= '0;
            pc4_q       <= '0;
            f3_q        <= '0;
            load_q      <= '0;
            a3_hold_q   <= '0;
            wd3_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            src_q       <= src_d;
            alu_q       <= alu_d;
            pc4_q       <= pc4_d;
            f3_q        <= f3_d;
            load_q      <= load_d;
            a3_hold_q   <= a3_hold_d;
            wd3_hold_q  <= wd3_hold_d;
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid = rf_we3;
    assign fwd_rd    = rf_a3;
    assign fwd_data  = rf_wd3;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus pushes expected writes, a monitor pops them.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_result_src;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [2:0]  in_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        rf_we3;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_result_src (in_result_src),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .in_funct3     (in_funct3),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .flush         (flush),
        .rf_a3         (rf_a3),
        .rf_wd3        (rf_wd3),
        .rf_we3        (rf_we3),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
    );

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd3;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a write is expected exactly in the cycle recorded by the stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_we;
            exp_t e;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_write: rd %0d data %h expected in cycle %0d", sb[0].a3, sb[0].wd3, sb[0].cyc);
                void'(sb.pop_front());
            end
            exp_we = (sb.size() > 0) && (sb[0].cyc == cyc);
            e = '{a3: 5'd0, wd3: 32'd0, cyc: 0};
            if (exp_we) e = sb.pop_front();
            chk("rf_we3", {31'd0, rf_we3}, {31'd0, exp_we});
            if (exp_we) begin
                chk("rf_a3", {27'd0, rf_a3}, {27'd0, e.a3});
                chk("rf_wd3", rf_wd3, e.wd3);
            end
`ifdef WB_FORWARD_EN
            chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, exp_we});
            if (exp_we) begin
                chk("fwd_rd", {27'd0, fwd_rd}, {27'd0, e.a3});
                chk("fwd_data", fwd_data, e.wd3);
            end
`else
            chk("fwd_tied", {26'd0, fwd_valid, fwd_rd} | fwd_data, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                         input logic [31:0] exp_wd);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_reg_write  = rw;
        in_result_src = src;
        in_alu_result = alu;
        in_pc_plus4   = pc4;
        in_funct3     = f3;
        if (rw && rd != 5'd0 && src != 2'b01)
            sb.push_back('{a3: rd, wd3: exp_wd, cyc: cyc + 1});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp_wd, input int gap);
        issue(rd, 1'b1, 2'b01, addr, 32'd0, f3, 32'd0);
        for (int i = 0; i < gap; i++) begin
            chk({name, "_ready_wait"}, {31'd0, in_ready}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        sb.push_back('{a3: rd, wd3: exp_wd, cyc: cyc + 1});
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_result_src = '0;
        in_alu_result = '0; in_pc_plus4 = '0; in_funct3 = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0;
        tick();
        tick();
        chk("reset_we3", {31'd0, rf_we3}, 32'd0);
        chk("reset_a3", {27'd0, rf_a3}, 32'd0);
        chk("reset_wd3", rf_wd3, 32'd0);
        chk("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        issue(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'd0, 3'd0, 32'h1234_5678);
        tick();

        for (int i = 1; i <= 3; i++) begin
            chk("b2b_ready", {31'd0, in_ready}, 32'd1);
            issue(i[4:0], 1'b1, 2'b00, 32'h1111_1111 * i, 32'd0, 3'd0, 32'h1111_1111 * i);
        end
        tick();

        do_load("lb",   5'd7, 3'b000, 32'h0000_1002, 32'h0080_0000, 32'hFFFF_FF80, 2);
        do_load("lbu",  5'd7, 3'b100, 32'h0000_1002, 32'h0080_0000, 32'h0000_0080, 2);
        do_load("lh",   5'd8, 3'b001, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001, 1);
        do_load("lhu",  5'd8, 3'b101, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001, 0);
        do_load("lh3",  5'd9, 3'b001, 32'h0000_2003, 32'h8001_0000, 32'hFFFF_8001, 1);
        do_load("lw",   5'd9, 3'b010, 32'h0000_3001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        do_load("bad",  5'd9, 3'b011, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0000_0000, 1);
        do_load("lb0",  5'd10, 3'b000, 32'h0000_3000, 32'h1234_567F, 32'h0000_007F, 1);
        // Accept directly in the WRITE cycle of a load.
        chk("ready_in_write", {31'd0, in_ready}, 32'd1);
        do_load("lb3",  5'd11, 3'b000, 32'h0000_3003, 32'hFE00_0000, 32'hFFFF_FFFE, 1);
        issue(5'd12, 1'b1, 2'b00, 32'h0000_00AA, 32'd0, 3'd0, 32'h0000_00AA);
        tick();

        issue(5'd0, 1'b1, 2'b10, 32'h0000_0050, 32'h0000_0104, 3'd0, 32'd0);
        issue(5'd1, 1'b1, 2'b10, 32'h0000_0050, 32'h0000_0104, 3'd0, 32'h0000_0104);
        issue(5'd4, 1'b1, 2'b11, 32'hCAFE_F00D, 32'h0000_0200, 3'd0, 32'hCAFE_F00D);
        issue(5'd6, 1'b0, 2'b00, 32'h0000_0999, 32'd0, 3'd0, 32'd0);
        tick();

        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rvalid_ready", {31'd0, in_ready}, 32'd1);

        // Flush while waiting: the late response is drained, not written.
        issue(5'd9, 1'b1, 2'b01, 32'h0000_4000, 32'd0, 3'b010, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_ready0", {31'd0, in_ready}, 32'd0);
        tick();
        chk("drain_ready1", {31'd0, in_ready}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        chk("drain_done_ready", {31'd0, in_ready}, 32'd1);

        issue(5'd11, 1'b1, 2'b01, 32'h0000_4000, 32'd0, 3'b010, 32'd0);
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8888_8888;
        tick();
        flush = 1'b0; mem_rvalid = 1'b0;
        chk("flush_rvalid_ready", {31'd0, in_ready}, 32'd1);

        // Flush during WRITE keeps the committed write but blocks the new accept.
        issue(5'd12, 1'b1, 2'b00, 32'h0000_0077, 32'd0, 3'd0, 32'h0000_0077);
        in_valid = 1'b1; in_rd = 5'd13; in_reg_write = 1'b1; in_result_src = 2'b00;
        in_alu_result = 32'h0000_0066; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        tick();

        issue(5'd14, 1'b1, 2'b00, 32'h0000_ABCD, 32'd0, 3'd0, 32'h0000_ABCD);
        issue(5'd10, 1'b1, 2'b01, 32'h0000_5000, 32'd0, 3'b010, 32'd0);
        chk("pre_reset_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we3", {31'd0, rf_we3}, 32'd0);
        chk("async_a3", {27'd0, rf_a3}, 32'd0);
        chk("async_wd3", rf_wd3, 32'd0);
        chk("async_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("async_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
        tick();
        mem_rvalid = 1'b0;
        issue(5'd15, 1'b1, 2'b00, 32'h0000_0005, 32'd0, 3'd0, 32'h0000_0005);
        repeat (3) tick();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
